// File: rtl/datapath_sequencer.sv
// datapath_sequencer: LOAD/RUN control FSM for the serial-load datapath.
// Drains input-buffer bytes into program memory, then issues each loaded address to the execute unit.
module datapath_sequencer #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      ADDR_W   = 4,
    parameter int unsigned      PC_W     = 8,
    parameter logic [WIDTH-1:0] END_CODE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              buf_ready,
    input  logic [WIDTH-1:0]  buf_data,
    output logic              buf_store,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [PC_W-1:0]   pc,
    output logic              pc_clr,
    output logic              pc_inc,
    output logic              exec_valid,
    output logic [ADDR_W-1:0] exec_addr,
    input  logic              exec_ready,
    output logic [ADDR_W:0]   prog_len,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WAIT,
        S_LOAD_WRITE,
        S_RUN_ISSUE,
        S_RUN_ADV,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     w_count_next;
    logic [ADDR_W:0]     w_count_inc;
    logic [ADDR_W:0]     r_prog_len;
    logic [ADDR_W:0]     w_prog_len_next;
    logic [ADDR_W-1:0]   r_mem_waddr;
    logic [ADDR_W-1:0]   w_mem_waddr_next;
    logic [WIDTH-1:0]    r_mem_wdata;
    logic [WIDTH-1:0]    w_mem_wdata_next;
    logic                r_buf_store;
    logic                w_buf_store_next;
    logic                r_mem_we;
    logic                w_mem_we_next;
    logic                r_pc_clr;
    logic                w_pc_clr_next;
    logic                r_pc_inc;
    logic                w_pc_inc_next;
    logic                r_exec_valid;
    logic                w_exec_valid_next;
    logic                w_last;

    assign w_count_inc = r_count + ONE;
    // Modular compare keeps the full-depth program (prog_len = 2**ADDR_W) correct for any PC_W.
    assign w_last      = (pc == (PC_W'(r_prog_len) - PC_W'(1)));

    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_prog_len_next   = r_prog_len;
        w_mem_waddr_next  = r_mem_waddr;
        w_mem_wdata_next  = r_mem_wdata;
        w_buf_store_next  = 1'b0;
        w_mem_we_next     = 1'b0;
        w_pc_clr_next     = 1'b0;
        w_pc_inc_next     = 1'b0;
        w_exec_valid_next = 1'b0;

        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_next    = S_LOAD_WAIT;
                        w_count_next    = '0;
                        w_prog_len_next = '0;
                        w_pc_clr_next   = 1'b1;
                    end
                end
                S_LOAD_WAIT: begin
                    if (buf_ready) begin
                        w_buf_store_next = 1'b1;
                        if (buf_data == END_CODE) begin
                            w_prog_len_next = r_count;
                            if (r_count == '0) begin
                                w_state_next = S_DONE;
                            end else begin
                                w_state_next      = S_RUN_ISSUE;
                                w_pc_clr_next     = 1'b1;
                                w_exec_valid_next = 1'b1;
                            end
                        end else begin
                            w_state_next     = S_LOAD_WRITE;
                            w_mem_we_next    = 1'b1;
                            w_mem_waddr_next = r_count[ADDR_W-1:0];
                            w_mem_wdata_next = buf_data;
                        end
                    end
                end
                S_LOAD_WRITE: begin
                    w_count_next = w_count_inc;
                    if (w_count_inc == DEPTH) begin
                        w_prog_len_next   = DEPTH;
                        w_state_next      = S_RUN_ISSUE;
                        w_pc_clr_next     = 1'b1;
                        w_exec_valid_next = 1'b1;
                    end else begin
                        w_state_next = S_LOAD_WAIT;
                    end
                end
                S_RUN_ISSUE: begin
                    if (r_exec_valid && exec_ready) begin
                        if (w_last) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_state_next  = S_RUN_ADV;
                            w_pc_inc_next = 1'b1;
                        end
                    end else begin
                        w_exec_valid_next = 1'b1;
                    end
                end
                S_RUN_ADV: begin
                    w_state_next      = S_RUN_ISSUE;
                    w_exec_valid_next = 1'b1;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_prog_len   <= '0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= '0;
            r_buf_store  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_pc_clr     <= 1'b0;
            r_pc_inc     <= 1'b0;
            r_exec_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_prog_len   <= w_prog_len_next;
            r_mem_waddr  <= w_mem_waddr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_buf_store  <= w_buf_store_next;
            r_mem_we     <= w_mem_we_next;
            r_pc_clr     <= w_pc_clr_next;
            r_pc_inc     <= w_pc_inc_next;
            r_exec_valid <= w_exec_valid_next;
        end
    end

    assign buf_store  = r_buf_store;
    assign mem_we     = r_mem_we;
    assign mem_waddr  = r_mem_waddr;
    assign mem_wdata  = r_mem_wdata;
    assign pc_clr     = r_pc_clr;
    assign pc_inc     = r_pc_inc;
    assign exec_valid = r_exec_valid;
    assign exec_addr  = pc[ADDR_W-1:0];
    assign prog_len   = r_prog_len;
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: scoreboard of expected writes/issues, environment-side PC model.
module tb_datapath_sequencer;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       buf_ready = 1'b0;
    logic [7:0] buf_data = 8'h00;
    logic       exec_ready = 1'b0;
    logic [7:0] pc;
    logic       buf_store, mem_we, pc_clr, pc_inc, exec_valid, busy, done;
    logic [3:0] mem_waddr, exec_addr;
    logic [7:0] mem_wdata;
    logic [4:0] prog_len;

    int checks = 0;
    int failures = 0;

    logic [7:0] feed_q[$];
    wr_t        exp_wr_q[$];
    int         exp_iss_q[$];

    datapath_sequencer #(
        .WIDTH(8), .ADDR_W(4), .PC_W(8), .END_CODE(8'hFF)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .buf_ready(buf_ready), .buf_data(buf_data), .buf_store(buf_store),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .pc(pc), .pc_clr(pc_clr), .pc_inc(pc_inc),
        .exec_valid(exec_valid), .exec_addr(exec_addr), .exec_ready(exec_ready),
        .prog_len(prog_len), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Program counter register living outside the sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        pc <= '0;
        else if (pc_clr) pc <= '0;
        else if (pc_inc) pc <= pc + 8'd1;
    end

    // Start a session, then feed bytes and accept issues until DONE with all queues drained.
    task automatic run_session(input int stall_addr, input int stall_cycles,
                               input int abort_addr, output bit aborted);
        int  stall_left;
        bit  finished;
        wr_t w;
        stall_left = stall_cycles;
        aborted    = 1'b0;
        finished   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (pc_clr !== 1'b1) begin failures++; $display("FAIL start_pc_clr got=%b exp=1", pc_clr); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", busy); end
        buf_ready = (feed_q.size() != 0);
        buf_data  = (feed_q.size() != 0) ? feed_q[0] : 8'h00;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(negedge clk);
            checks++;
            if ((pc_clr & pc_inc) !== 1'b0) begin
                failures++; $display("FAIL pc_clr_and_inc got=1 exp=0");
            end
            if (buf_store === 1'b1) begin
                checks++;
                if (feed_q.size() == 0) begin
                    failures++; $display("FAIL buf_store_extra got=1 exp=0");
                end else begin
                    void'(feed_q.pop_front());
                end
                buf_ready = (feed_q.size() != 0);
                buf_data  = (feed_q.size() != 0) ? feed_q[0] : 8'h00;
            end
            if (mem_we === 1'b1) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    failures++; $display("FAIL mem_we_extra addr=%0h data=%0h exp=no write", mem_waddr, mem_wdata);
                end else begin
                    w = exp_wr_q.pop_front();
                    if ({mem_waddr, mem_wdata} !== {w.addr, w.data}) begin
                        failures++;
                        $display("FAIL mem_write got=%0h/%0h exp=%0h/%0h", mem_waddr, mem_wdata, w.addr, w.data);
                    end
                end
            end
            if (exec_valid === 1'b1) begin
                checks++;
                if (exp_iss_q.size() == 0) begin
                    failures++; $display("FAIL exec_extra addr=%0h exp=no issue", exec_addr);
                    exec_ready = 1'b1;
                end else begin
                    if (exec_addr !== 4'(exp_iss_q[0])) begin
                        failures++; $display("FAIL exec_addr got=%0h exp=%0h", exec_addr, exp_iss_q[0]);
                    end
                    if (exp_iss_q[0] == stall_addr && stall_left > 0) begin
                        exec_ready = 1'b0;
                        stall_left--;
                        checks++;
                        if (pc_inc !== 1'b0) begin failures++; $display("FAIL stall_pc_inc got=%b exp=0", pc_inc); end
                    end else if (exp_iss_q[0] == abort_addr) begin
                        abort      = 1'b1;
                        exec_ready = 1'b0;
                        aborted    = 1'b1;
                        finished   = 1'b1;
                    end else begin
                        exec_ready = 1'b1;
                        void'(exp_iss_q.pop_front());
                    end
                end
            end else begin
                exec_ready = 1'b0;
            end
            if (!finished && done === 1'b1 && exp_wr_q.size() == 0 &&
                exp_iss_q.size() == 0 && feed_q.size() == 0)
                finished = 1'b1;
        end
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL session_timeout wr_left=%0d iss_left=%0d feed_left=%0d exp=0/0/0",
                     exp_wr_q.size(), exp_iss_q.size(), feed_q.size());
        end
        exec_ready = 1'b0;
        buf_ready  = 1'b0;
    endtask

    task automatic queue_program(input int n, input logic [7:0] base, input bit term);
        for (int i = 0; i < n; i++) begin
            feed_q.push_back(base + 8'(i));
            exp_wr_q.push_back('{addr: 4'(i), data: base + 8'(i)});
            exp_iss_q.push_back(i);
        end
        if (term) feed_q.push_back(8'hFF);
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({buf_store, mem_we, pc_clr, pc_inc, exec_valid, busy, done, prog_len, mem_waddr, mem_wdata} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=0",
                {buf_store, mem_we, pc_clr, pc_inc, exec_valid, busy, done, prog_len, mem_waddr, mem_wdata});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, exec_valid, pc_clr, exec_addr} !== '0) begin
            failures++; $display("FAIL reset_idle got=%b exp=0", {busy, done, exec_valid, pc_clr, exec_addr});
        end
    endtask

    task automatic test_load_run();
        bit ab;
        queue_program(3, 8'h11, 1'b1);
        exp_wr_q.delete();
        exp_wr_q.push_back('{addr: 4'd0, data: 8'h11});
        exp_wr_q.push_back('{addr: 4'd1, data: 8'h22});
        exp_wr_q.push_back('{addr: 4'd2, data: 8'h33});
        feed_q.delete();
        feed_q = '{8'h11, 8'h22, 8'h33, 8'hFF};
        run_session(-1, 0, -1, ab);
        checks++;
        if (prog_len !== 5'd3) begin failures++; $display("FAIL t1_prog_len got=%0d exp=3", prog_len); end
        checks++;
        if ({done, busy} !== 2'b10) begin failures++; $display("FAIL t1_done_busy got=%b exp=10", {done, busy}); end
    endtask

    task automatic test_stall();
        bit ab;
        queue_program(4, 8'hA0, 1'b1);
        run_session(1, 5, -1, ab);
        checks++;
        if (prog_len !== 5'd4) begin failures++; $display("FAIL t4_prog_len got=%0d exp=4", prog_len); end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL t4_done got=%b exp=1", done); end
    endtask

    task automatic test_empty();
        bit ab;
        feed_q.push_back(8'hFF);
        run_session(-1, 0, -1, ab);
        checks++;
        if (prog_len !== 5'd0) begin failures++; $display("FAIL t2_prog_len got=%0d exp=0", prog_len); end
        checks++;
        if ({done, busy} !== 2'b10) begin failures++; $display("FAIL t2_done_busy got=%b exp=10", {done, busy}); end
    endtask

    task automatic test_full();
        bit ab;
        queue_program(16, 8'h00, 1'b0);
        run_session(-1, 0, -1, ab);
        checks++;
        if (prog_len !== 5'd16) begin failures++; $display("FAIL t3_prog_len got=%0d exp=16", prog_len); end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL t3_done got=%b exp=1", done); end
    endtask

    task automatic test_abort();
        bit ab;
        queue_program(4, 8'h51, 1'b1);
        run_session(-1, 0, 2, ab);
        checks++;
        if (ab !== 1'b1) begin failures++; $display("FAIL t5_reached_addr2 got=%b exp=1", ab); end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, done, exec_valid} !== 3'b000) begin
            failures++; $display("FAIL t5_idle got=%b exp=000", {busy, done, exec_valid});
        end
        checks++;
        if (prog_len !== 5'd4) begin failures++; $display("FAIL t5_prog_len_kept got=%0d exp=4", prog_len); end
        exp_iss_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({pc_clr, pc_inc, busy} !== 3'b101) begin
            failures++; $display("FAIL t5_restart got=%b exp=101", {pc_clr, pc_inc, busy});
        end
        @(negedge clk);
        checks++;
        if ({pc_clr, pc} !== 9'd0) begin failures++; $display("FAIL t5_pc_cleared got=%b exp=0", {pc_clr, pc}); end
    endtask

    task automatic test_reset_midload();
        bit seen;
        seen      = 1'b0;
        buf_ready = 1'b1;
        buf_data  = 8'hA5;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_we === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL t6_write_timeout got=no mem_we exp=mem_we"); end
        checks++;
        if ({buf_store, mem_waddr, mem_wdata} !== {1'b1, 4'd0, 8'hA5}) begin
            failures++; $display("FAIL t6_write got=%0h exp=%0h", {buf_store, mem_waddr, mem_wdata}, {1'b1, 4'd0, 8'hA5});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({buf_store, mem_we, pc_clr, pc_inc, exec_valid, busy, done, prog_len, mem_waddr, mem_wdata} !== '0) begin
            failures++; $display("FAIL t6_async_clear got=%b exp=0",
                {buf_store, mem_we, pc_clr, pc_inc, exec_valid, busy, done, prog_len, mem_waddr, mem_wdata});
        end
        buf_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, mem_we, buf_store, prog_len} !== '0) begin
            failures++; $display("FAIL t6_idle_after got=%b exp=0", {busy, done, mem_we, buf_store, prog_len});
        end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_stall();
        test_empty();
        test_full();
        test_abort();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
